// File: rtl/uart_cmd_scheduler.sv
// Command decoder and transmit scheduler for the frequency-report UART path.
// Decodes command words, holds one pending request per response type, and
// arbitrates the single UART transmitter with a send pulse / done handshake.
module uart_cmd_scheduler #(
    parameter logic [31:0] CMD_READ   = 32'hFFFFA5A5,
    parameter logic [23:0] CMD_PERIOD = 24'hFFFFA6,
    parameter logic [31:0] CMD_STATUS = 32'hFFFFA7A7,
    parameter logic [31:0] CMD_CLEAR  = 32'hFFFFA8A8,
    parameter logic [31:0] NAK_WORD   = 32'hFFFFEEEE,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned TX_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_data,
    input  logic        rx_done,
    input  logic [15:0] high_cnt,
    input  logic [15:0] low_cnt,
    input  logic        tx_done,
    output logic [31:0] tx_data,
    output logic        tx_send_en,
    output logic        busy,
    output logic        err_flag,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_t;

    state_t      state;
    logic        rx_valid;
    logic [31:0] rx_word;
    logic [7:0]  auto_period;
    logic [31:0] tick_cnt;
    logic [7:0]  unit_cnt;
    logic [31:0] tmo_cnt;
    logic        pend_nak, pend_read, pend_stat, pend_auto;

    logic        cmd_read, cmd_stat, cmd_period, cmd_clear, cmd_nak;
    logic        grant_nak, grant_read, grant_stat, grant_auto, any_grant;
    logic [31:0] grant_word;
    logic        tick_wrap, auto_fire, set_auto;
    logic        drop_nak, drop_read, drop_stat, drop_auto;
    logic [1:0]  drop_inc;
    logic [8:0]  drop_sum;

    // A set wins over a same-cycle grant, so the request is never lost.
    function automatic logic next_pend(input logic pend, input logic set, input logic grant);
        return set | (pend & ~grant);
    endfunction

    // Register the incoming command so decode runs one edge after rx_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_word  <= 32'd0;
        end else begin
            rx_valid <= rx_done;
            if (rx_done) rx_word <= rx_data;
        end
    end

    // Decode the registered command word.
    always_comb begin
        cmd_read   = 1'b0;
        cmd_stat   = 1'b0;
        cmd_period = 1'b0;
        cmd_clear  = 1'b0;
        cmd_nak    = 1'b0;
        if (rx_valid) begin
            if (rx_word == CMD_READ)               cmd_read   = 1'b1;
            else if (rx_word == CMD_STATUS)        cmd_stat   = 1'b1;
            else if (rx_word[31:8] == CMD_PERIOD)  cmd_period = 1'b1;
            else if (rx_word == CMD_CLEAR)         cmd_clear  = 1'b1;
            else                                   cmd_nak    = 1'b1;
        end
    end

    // Fixed-priority grant, only while idle: nak > read > status > auto.
    always_comb begin
        grant_nak  = 1'b0;
        grant_read = 1'b0;
        grant_stat = 1'b0;
        grant_auto = 1'b0;
        grant_word = 32'd0;
        if (state == StIdle) begin
            if (pend_nak) begin
                grant_nak  = 1'b1;
                grant_word = NAK_WORD;
            end else if (pend_read) begin
                grant_read = 1'b1;
                grant_word = {high_cnt, low_cnt};
            end else if (pend_stat) begin
                grant_stat = 1'b1;
                grant_word = {8'hA7, auto_period, drop_cnt, 7'b0, err_flag};
            end else if (pend_auto) begin
                grant_auto = 1'b1;
                grant_word = {high_cnt, low_cnt};
            end
        end
    end

    assign any_grant = grant_nak | grant_read | grant_stat | grant_auto;

    assign tick_wrap = (auto_period != 8'd0) && (tick_cnt == TICK_DIV - 1);
    assign auto_fire = tick_wrap && (unit_cnt + 8'd1 == auto_period);
    // A period command restarts the timer, so it suppresses a coincident fire.
    assign set_auto  = auto_fire && !cmd_period;

    assign drop_nak  = cmd_nak  & pend_nak  & ~grant_nak;
    assign drop_read = cmd_read & pend_read & ~grant_read;
    assign drop_stat = cmd_stat & pend_stat & ~grant_stat;
    assign drop_auto = set_auto & pend_auto & ~grant_auto;
    assign drop_inc  = {1'b0, drop_nak} + {1'b0, drop_read} + {1'b0, drop_stat}
                     + {1'b0, drop_auto};
    assign drop_sum  = {1'b0, drop_cnt} + {7'b0, drop_inc};

    // Auto-report timer, period register, pending flags and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_period <= 8'd0;
            tick_cnt    <= 32'd0;
            unit_cnt    <= 8'd0;
            pend_nak    <= 1'b0;
            pend_read   <= 1'b0;
            pend_stat   <= 1'b0;
            pend_auto   <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            if (cmd_period) begin
                auto_period <= rx_word[7:0];
                tick_cnt    <= 32'd0;
                unit_cnt    <= 8'd0;
            end else if (auto_period != 8'd0) begin
                if (tick_wrap) begin
                    tick_cnt <= 32'd0;
                    unit_cnt <= auto_fire ? 8'd0 : unit_cnt + 8'd1;
                end else begin
                    tick_cnt <= tick_cnt + 32'd1;
                end
            end

            pend_nak  <= next_pend(pend_nak, cmd_nak, grant_nak);
            pend_read <= next_pend(pend_read, cmd_read, grant_read);
            pend_stat <= next_pend(pend_stat, cmd_stat, grant_stat);
            if (cmd_period && rx_word[7:0] == 8'd0) pend_auto <= 1'b0;
            else pend_auto <= next_pend(pend_auto, set_auto, grant_auto);

            if (cmd_clear)             drop_cnt <= 8'd0;
            else if (drop_inc != 2'd0) drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Transmit sequencer with registered outputs and timeout abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            tx_data    <= 32'd0;
            tx_send_en <= 1'b0;
            busy       <= 1'b0;
            err_flag   <= 1'b0;
            tmo_cnt    <= 32'd0;
        end else begin
            tx_send_en <= 1'b0;
            if (cmd_clear) err_flag <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (any_grant) begin
                        state      <= StSend;
                        tx_data    <= grant_word;
                        tx_send_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                StSend: begin
                    state   <= StWait;
                    tmo_cnt <= 32'd0;
                end
                StWait: begin
                    if (tx_done) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (tmo_cnt == TX_TIMEOUT - 1) begin
                        err_flag <= 1'b1;
                        state    <= StIdle;
                        busy     <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Scoreboard bench for uart_cmd_scheduler: stimulus pushes expected tx words,
// a monitor pops and compares on every tx_send_en pulse.
module tb_uart_cmd_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] rx_data;
    logic        rx_done;
    logic [15:0] high_cnt;
    logic [15:0] low_cnt;
    logic        tx_done;
    logic [31:0] tx_data;
    logic        tx_send_en;
    logic        busy;
    logic        err_flag;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sends = 0;
    int last_send_cyc = 0;
    int cmd_cyc = 0;
    int done_cyc = 0;
    int prev_send;
    int snap;
    logic [31:0] exp_q[$];

    uart_cmd_scheduler #(
        .TICK_DIV  (10),
        .TX_TIMEOUT(50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .high_cnt  (high_cnt),
        .low_cnt   (low_cnt),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .tx_send_en(tx_send_en),
        .busy      (busy),
        .err_flag  (err_flag),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every send pulse must match the oldest expected word.
    always @(posedge clk) begin
        #1;
        if (tx_send_en === 1'b1) begin
            sends++;
            last_send_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_send: got %h expected no pulse", tx_data);
            end else begin
                check("tx_word", tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [31:0] word);
        @(negedge clk);
        rx_data = word;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        cmd_cyc = cyc;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        done_cyc = cyc;
    endtask

    task automatic wait_send(input string name);
        int start;
        start = sends;
        for (int i = 0; i < 200 && sends == start; i++) @(negedge clk);
        checks++;
        if (sends == start) begin
            errors++;
            $display("FAIL %s: got no send pulse expected one within 200 cycles", name);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_data = 32'd0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        high_cnt = 16'h1234;
        low_cnt = 16'h5678;
        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_send_en", {31'd0, tx_send_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err_flag}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        rst = 1'b0;

        // Single read, done 20 cycles after the pulse.
        exp_q.push_back(32'h12345678);
        send_cmd(32'hFFFFA5A5);
        wait_send("read_send");
        check("read_latency", last_send_cyc - cmd_cyc, 32'd2);
        repeat (19) @(negedge clk);
        check("read_busy_high", {31'd0, busy}, 32'd1);
        pulse_done();
        check("read_busy_fall", {31'd0, busy}, 32'd0);

        // Priority: NAK beats a read queued in the same WAIT.
        high_cnt = 16'hAAAA;
        low_cnt = 16'h5555;
        exp_q.push_back(32'hAAAA5555);
        send_cmd(32'hFFFFA5A5);
        wait_send("prio_first");
        exp_q.push_back(32'hFFFFEEEE);
        exp_q.push_back(32'hAAAA5555);
        send_cmd(32'h00000001);
        send_cmd(32'hFFFFA5A5);
        pulse_done();
        wait_send("prio_nak");
        check("grant_gap", last_send_cyc - done_cyc, 32'd1);
        pulse_done();
        wait_send("prio_read");
        pulse_done();
        check("prio_drop", {24'd0, drop_cnt}, 32'd0);

        // Drop: three reads during WAIT, then status reports two drops.
        exp_q.push_back(32'hAAAA5555);
        send_cmd(32'hFFFFA5A5);
        wait_send("drop_first");
        exp_q.push_back(32'hAAAA5555);
        send_cmd(32'hFFFFA5A5);
        send_cmd(32'hFFFFA5A5);
        send_cmd(32'hFFFFA5A5);
        exp_q.push_back(32'hA7000200);
        send_cmd(32'hFFFFA7A7);
        repeat (2) @(negedge clk);
        check("drop_cnt2", {24'd0, drop_cnt}, 32'd2);
        pulse_done();
        wait_send("drop_read");
        pulse_done();
        wait_send("drop_status");
        pulse_done();

        // Auto-report every 3 units of 10 cycles.
        repeat (3) exp_q.push_back(32'hAAAA5555);
        send_cmd(32'hFFFFA603);
        wait_send("auto1");
        check("auto_first_latency", last_send_cyc - cmd_cyc, 32'd32);
        prev_send = last_send_cyc;
        pulse_done();
        wait_send("auto2");
        check("auto_gap1", last_send_cyc - prev_send, 32'd30);
        prev_send = last_send_cyc;
        pulse_done();
        wait_send("auto3");
        check("auto_gap2", last_send_cyc - prev_send, 32'd30);
        pulse_done();
        send_cmd(32'hFFFFA600);
        snap = sends;
        repeat (100) @(negedge clk);
        check("auto_disabled", sends - snap, 32'd0);

        // Timeout: no tx_done.
        exp_q.push_back(32'hAAAA5555);
        send_cmd(32'hFFFFA5A5);
        wait_send("tmo_send");
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (err_flag === 1'b1) break;
        end
        check("tmo_cycles", cyc - last_send_cyc, 32'd51);
        check("tmo_err", {31'd0, err_flag}, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        send_cmd(32'hFFFFA8A8);
        @(negedge clk);
        check("clear_err", {31'd0, err_flag}, 32'd0);
        check("clear_drop", {24'd0, drop_cnt}, 32'd0);

        // Reset mid-WAIT, then a stray tx_done.
        exp_q.push_back(32'hAAAA5555);
        send_cmd(32'hFFFFA5A5);
        wait_send("rst_send");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx_data", tx_data, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_send_en", {31'd0, tx_send_en}, 32'd0);
        snap = sends;
        pulse_done();
        repeat (10) @(negedge clk);
        check("stray_done", sends - snap, 32'd0);
        check("stray_busy", {31'd0, busy}, 32'd0);

        // Normal operation resumes after reset.
        high_cnt = 16'h0F0F;
        low_cnt = 16'hC3C3;
        exp_q.push_back(32'h0F0FC3C3);
        send_cmd(32'hFFFFA5A5);
        wait_send("post_rst_send");
        pulse_done();
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
